// File: rtl/ps2_key_input.sv
// Purpose : PS/2 keyboard receiver; decodes make/break codes into held-key levels.
// Latency : scan_valid and key levels update 2 clk after the stop-bit fall is registered.
// Backpr. : none; the keyboard cannot be stalled, so bytes are dropped only on error.
// Ports   : clk, reset (async, active-low), ps2c/ps2d (async pins);
//           left/right/drop (held levels), scan_code + scan_valid (last good byte),
//           frame_err (one-cycle pulse on framing, parity or timeout error).
module ps2_key_input #(
  parameter int         FILTER_LEN     = 8,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] KEY_LEFT       = 8'h6B,
  parameter logic [7:0] KEY_RIGHT      = 8'h74,
  parameter logic [7:0] KEY_DROP       = 8'h29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       left,
  output logic       right,
  output logic       drop,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

  logic [1:0]     r_c_sync, r_d_sync;
  logic           r_filt;
  logic [FCW-1:0] r_fcnt;
  state_t         r_state, w_state_nxt;
  logic [3:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic [9:0]     r_shift, w_shift_nxt;
  logic [TCW-1:0] r_tcnt, w_tcnt_nxt;
  logic [7:0]     r_scan_code, w_code_nxt;
  logic           r_scan_valid, w_valid_nxt;
  logic           r_frame_err, w_err_nxt;
  logic           r_break, w_break_nxt;
  logic           r_left, w_left_nxt;
  logic           r_right, w_right_nxt;
  logic           r_drop, w_drop_nxt;
  logic           w_c, w_d, w_fall, w_frame_ok;
  logic [7:0]     w_byte;

  assign w_c = r_c_sync[1];
  assign w_d = r_d_sync[1];

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c_sync <= 2'b11;
      r_d_sync <= 2'b11;
    end else begin
      r_c_sync <= {r_c_sync[0], ps2c};
      r_d_sync <= {r_d_sync[0], ps2d};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
    end else if (w_c != r_filt) begin
      if (r_fcnt == FILT_LAST) begin
        r_filt <= w_c;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end else begin
      r_fcnt <= '0;
    end
  end

  // Fall is the cycle in which the filtered level is about to go 1->0;
  // the synchronized data bit is taken in that same cycle.
  assign w_fall     = r_filt & ~w_c & (r_fcnt == FILT_LAST);
  assign w_byte     = r_shift[7:0];
  assign w_frame_ok = (^r_shift[8:0]) & r_shift[9];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_tcnt       <= '0;
      r_scan_code  <= 8'h00;
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_break      <= 1'b0;
      r_left       <= 1'b0;
      r_right      <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_scan_code  <= w_code_nxt;
      r_scan_valid <= w_valid_nxt;
      r_frame_err  <= w_err_nxt;
      r_break      <= w_break_nxt;
      r_left       <= w_left_nxt;
      r_right      <= w_right_nxt;
      r_drop       <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_tcnt_nxt    = r_tcnt;
    w_code_nxt    = r_scan_code;
    w_valid_nxt   = 1'b0;
    w_err_nxt     = 1'b0;
    w_break_nxt   = r_break;
    w_left_nxt    = r_left;
    w_right_nxt   = r_right;
    w_drop_nxt    = r_drop;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          if (!w_d) begin
            w_state_nxt   = S_SHIFT;
            w_bit_cnt_nxt = '0;
            w_tcnt_nxt    = '0;
          end else begin
            w_err_nxt = 1'b1;  // idle fall without a start bit
          end
        end
      end
      S_SHIFT: begin
        if (w_fall) begin
          // LSB arrives first, so shift right: after 10 falls
          // [7:0]=data, [8]=parity, [9]=stop.
          w_shift_nxt   = {w_d, r_shift[9:1]};
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          w_tcnt_nxt    = '0;
          if (r_bit_cnt == 4'd9) w_state_nxt = S_CHECK;
        end else if (r_tcnt == TOUT_LAST) begin
          w_err_nxt   = 1'b1;
          w_break_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      S_CHECK: begin
        w_state_nxt = S_IDLE;
        if (w_frame_ok) begin
          w_code_nxt  = w_byte;
          w_valid_nxt = 1'b1;
          // E0 prefix is ignored so extended codes alias onto the base keys.
          if (w_byte == 8'hE0) begin
            w_break_nxt = r_break;
          end else if (w_byte == 8'hF0) begin
            w_break_nxt = 1'b1;
          end else begin
            w_break_nxt = 1'b0;
            if (w_byte == KEY_LEFT)  w_left_nxt  = ~r_break;
            if (w_byte == KEY_RIGHT) w_right_nxt = ~r_break;
            if (w_byte == KEY_DROP)  w_drop_nxt  = ~r_break;
          end
        end else begin
          w_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign left       = r_left;
  assign right      = r_right;
  assign drop       = r_drop;
  assign scan_code  = r_scan_code;
  assign scan_valid = r_scan_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_key_input.sv
// Bench for ps2_key_input: directed scenarios plus randomized byte streams,
// checked against a byte-level keyboard model (make/break/prefix rules).
module tb_ps2_key_input;

  localparam int TOUT = 1000;

  logic       clk = 1'b0;
  logic       reset, ps2c, ps2d;
  logic       left, right, drop, scan_valid, frame_err;
  logic [7:0] scan_code;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [2:0] keys_at_valid = 3'b000;

  // Reference model state
  logic       m_left = 1'b0, m_right = 1'b0, m_drop = 1'b0, m_brk = 1'b0;
  logic [7:0] m_code = 8'h00;

  ps2_key_input #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d),
    .left(left), .right(right), .drop(drop),
    .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (scan_valid === 1'b1) begin
      valid_cnt++;
      keys_at_valid = {left, right, drop};
    end
    if (frame_err === 1'b1) err_cnt++;
    if (scan_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Keyboard semantics applied to one correctly received byte.
  task automatic model_byte(input logic [7:0] b);
    m_code = b;
    if (b == 8'hE0) begin
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (b == 8'h6B) m_left  = !m_brk;
      if (b == 8'h74) m_right = !m_brk;
      if (b == 8'h29) m_drop  = !m_brk;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic bad, input int nbits, input int half);
    logic [10:0] fr;
    logic par;
    par = (~^b) ^ bad;
    fr = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2d = fr[i];
      repeat (half) @(negedge clk);
      ps2c = 1'b0;
      repeat (half) @(negedge clk);
      ps2c = 1'b1;
    end
  endtask

  task automatic frame_and_check(input string tag, input logic [7:0] b, input logic bad);
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(b, bad, 11, $urandom_range(15, 30));
    repeat (40) @(negedge clk);
    if (!bad) model_byte(b);
    check($sformatf("%s.valid", tag), valid_cnt - v0, bad ? 0 : 1);
    check($sformatf("%s.err", tag), err_cnt - e0, bad ? 1 : 0);
    check($sformatf("%s.code", tag), scan_code, m_code);
    check($sformatf("%s.keys", tag), {left, right, drop}, {m_left, m_right, m_drop});
    if (!bad) check($sformatf("%s.keys_at_valid", tag), keys_at_valid, {m_left, m_right, m_drop});
  endtask

  initial begin
    int v0, e0;
    logic [7:0] pool [6];
    logic [7:0] b;

    reset = 1'b0;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    repeat (5) @(negedge clk);
    check("reset.keys", {left, right, drop}, 3'b000);
    check("reset.code", scan_code, 8'h00);
    check("reset.strobes", {scan_valid, frame_err}, 2'b00);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // 1: make left
    frame_and_check("t1_6B", 8'h6B, 1'b0);
    // 2: break left
    frame_and_check("t2_F0", 8'hF0, 1'b0);
    frame_and_check("t2_6B", 8'h6B, 1'b0);
    // 3: extended right make then break
    v0 = valid_cnt;
    frame_and_check("t3_E0a", 8'hE0, 1'b0);
    frame_and_check("t3_74a", 8'h74, 1'b0);
    frame_and_check("t3_E0b", 8'hE0, 1'b0);
    frame_and_check("t3_F0",  8'hF0, 1'b0);
    frame_and_check("t3_74b", 8'h74, 1'b0);
    check("t3.pulses", valid_cnt - v0, 5);

    // 4: parity error, then a short clock glitch
    frame_and_check("t4_bad29", 8'h29, 1'b1);
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk);
    ps2c = 1'b0;
    repeat (3) @(negedge clk);
    ps2c = 1'b1;
    repeat (40) @(negedge clk);
    check("t4.glitch_pulses", {valid_cnt - v0, err_cnt - e0}, 0);
    check("t4.glitch_keys", {left, right, drop}, {m_left, m_right, m_drop});
    frame_and_check("t4_after_glitch", 8'h74, 1'b0);

    // 5: truncated frame times out
    frame_and_check("t5_F0", 8'hF0, 1'b0);
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(8'h55, 1'b0, 6, 20);
    repeat (TOUT / 2) @(negedge clk);
    check("t5.no_early_timeout", err_cnt - e0, 0);
    repeat (TOUT / 2 + 2 + 40) @(negedge clk);
    check("t5.timeout_err", err_cnt - e0, 1);
    check("t5.timeout_valid", valid_cnt - v0, 0);
    m_brk = 1'b0;  // timeout also drops a pending break
    frame_and_check("t5_29", 8'h29, 1'b0);

    // 6: asynchronous reset mid-frame
    frame_and_check("t6_6B", 8'h6B, 1'b0);
    send_bits(8'h74, 1'b0, 5, 20);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6.async_keys", {left, right, drop}, 3'b000);
    check("t6.async_code", scan_code, 8'h00);
    m_left = 1'b0; m_right = 1'b0; m_drop = 1'b0; m_brk = 1'b0; m_code = 8'h00;
    ps2c = 1'b1;
    ps2d = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    frame_and_check("t6_74", 8'h74, 1'b0);

    // Randomized byte stream against the model
    pool[0] = 8'h6B; pool[1] = 8'h74; pool[2] = 8'h29;
    pool[3] = 8'hE0; pool[4] = 8'hF0; pool[5] = 8'h00;
    for (int i = 0; i < 24; i++) begin
      int k;
      k = $urandom_range(0, 5);
      b = (k == 5) ? 8'($urandom) : pool[k];
      frame_and_check($sformatf("rnd%0d_%02h", i, b), b, ($urandom_range(0, 4) == 0));
    end

    check("never_both_strobes", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
